// File: rtl/serial_shift_controller.sv
// Multi-cycle shifter for sll/srl/sra/rol: steps a 32-bit register by 2 or 1 bit per cycle
// and returns the result through a start/busy/done handshake.
module serial_shift_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t      state_q;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [4:0]  count_q;
    logic [4:0]  count_d;
    logic [1:0]  op_q;
    logic [31:0] result_q;
    logic        busy_q;
    logic        done_q;
    logic        step_two;

    // Two fixed shift stages; the remaining count picks which one is applied this cycle.
    always_comb begin
        step_two = (count_q >= 5'd2);
        count_d  = step_two ? (count_q - 5'd2) : (count_q - 5'd1);
        data_d   = data_q;
        if (step_two) begin
            case (op_q)
                OP_SLL:  data_d = {data_q[29:0], 2'b00};
                OP_SRL:  data_d = {2'b00, data_q[31:2]};
                OP_SRA:  data_d = {{2{data_q[31]}}, data_q[31:2]};
                OP_ROL:  data_d = {data_q[29:0], data_q[31:30]};
                default: data_d = data_q;
            endcase
        end else begin
            case (op_q)
                OP_SLL:  data_d = {data_q[30:0], 1'b0};
                OP_SRL:  data_d = {1'b0, data_q[31:1]};
                OP_SRA:  data_d = {data_q[31], data_q[31:1]};
                OP_ROL:  data_d = {data_q[30:0], data_q[31]};
                default: data_d = data_q;
            endcase
        end
    end

    // result is loaded on the edge that enters DONE so it is valid alongside the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            data_q   <= 32'h0;
            count_q  <= 5'd0;
            op_q     <= 2'b00;
            result_q <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        data_q  <= operand;
                        count_q <= shamt;
                        op_q    <= op;
                        busy_q  <= 1'b1;
                        if (shamt == 5'd0) begin
                            state_q  <= S_DONE;
                            result_q <= operand;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q  <= data_d;
                    count_q <= count_d;
                    if (count_d == 5'd0) begin
                        state_q  <= S_DONE;
                        result_q <= data_d;
                        done_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_serial_shift_controller.sv
// Directed vector table plus hand sequences and an all-op/all-shamt sweep for serial_shift_controller.
module tb_serial_shift_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    serial_shift_controller dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] operand;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain single-step shift, independent of the 2/1 stepping.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s, input logic [31:0] x);
        logic [63:0] dbl;
        case (o)
            2'b00: return x << s;
            2'b01: return x >> s;
            2'b10: return $unsigned($signed(x) >>> s);
            default: begin
                dbl = {x, x} << s;
                return dbl[63:32];
            end
        endcase
    endfunction

    // Starts one op from IDLE (called #1 after an edge), checks result, latency, busy span, and the done pulse width.
    task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] s,
                          input logic [31:0] x, input logic [31:0] exp_res, input int exp_lat);
        int k;
        int busy_cnt;
        bit seen;
        start = 1'b1; op = o; shamt = s; operand = x;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; shamt = ~s; operand = ~x;
        seen = 0; busy_cnt = 0; k = 1;
        while (k <= 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done at cycle %0d", name, exp_lat);
        end else begin
            check({name, "_result"}, result, exp_res);
            check({name, "_latency"}, k, exp_lat);
            check({name, "_busy_cycles"}, busy_cnt, exp_lat);
            @(posedge clk); #1;
            check({name, "_done_width"}, {31'b0, done}, 32'h0);
            check({name, "_busy_fall"}, {31'b0, busy}, 32'h0);
            check({name, "_result_hold"}, result, exp_res);
        end
        $display("op=%0d shamt=%0d operand=%h -> result=%h done_cycle=%0d (%s)", o, s, x, result, k, name);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        logic [31:0] x;

        vecs[0] = '{2'b00, 5'd31, 32'h00000001, 32'h80000000, 17};
        vecs[1] = '{2'b10, 5'd4,  32'h80000000, 32'hF8000000, 3};
        vecs[2] = '{2'b01, 5'd4,  32'h80000000, 32'h08000000, 3};
        vecs[3] = '{2'b10, 5'd3,  32'h7FFFFFF0, 32'h0FFFFFFE, 3};
        vecs[4] = '{2'b11, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[5] = '{2'b11, 5'd1,  32'h80000001, 32'h00000003, 2};
        vecs[6] = '{2'b11, 5'd8,  32'h12345678, 32'h34567812, 5};
        vecs[7] = '{2'b10, 5'd31, 32'hF0000000, 32'hFFFFFFFF, 17};
        vecs[8] = '{2'b01, 5'd31, 32'hFFFFFFFF, 32'h00000001, 17};
        vecs[9] = '{2'b00, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};

        reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; operand = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].operand,
                   vecs[i].exp_result, vecs[i].exp_lat);
        end

        // start while busy must be ignored
        start = 1'b1; op = 2'b00; shamt = 5'd10; operand = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0; done_cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin
                start = 1'b1; op = 2'b01; shamt = 5'd1; operand = 32'hFFFFFFFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
                check("ignored_start_result", result, 32'h00000400);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_done_cycle", done_cyc, 6);
        $display("ignored-start sequence: done pulses=%0d at cycle %0d result=%h", done_cnt, done_cyc, result);

        // reset in the middle of a shift discards it
        start = 1'b1; op = 2'b00; shamt = 5'd20; operand = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_done", {31'b0, done}, 32'h0);
        check("midreset_result", result, 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) done_cnt++;
            @(posedge clk); #1;
        end
        check("midreset_no_done", done_cnt, 0);
        $display("mid-op reset sequence: activity after reset=%0d result=%h", done_cnt, result);
        run_op("post_reset", 2'b01, 5'd8, 32'h00000100, 32'h00000001, 5);

        // sweep every op and shamt against the reference model
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 32; s++) begin
                x = $urandom;
                run_op($sformatf("sweep_op%0d_sh%0d", o, s), o[1:0], s[4:0], x,
                       ref_shift(o[1:0], s[4:0], x), 1 + (s + 1) / 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
